// File: rtl/mouse_ctrl_pkg.sv
// Shared types and register offsets for the mouse sprite controller.
// Pure declarations, no logic or latency.
// Bus-side constants only; flow control lives in the modules.
package mouse_ctrl_pkg;

  typedef enum logic {IDLE, FILL} fill_state_t;

  localparam logic [1:0] REG_POS  = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_FILL = 2'd2;
  localparam logic [1:0] REG_CMD  = 2'd3;

  localparam logic RD_STATUS = 1'b0;
  localparam logic RD_POS    = 1'b1;

endpackage

// File: rtl/sprite_fill_engine.sv
// Fill FSM, word counter and sprite RAM write-port arbiter (CPU beats fill).
// Latency: one cycle from CPU write or fill step to registered RAM port.
// Backpressure: a CPU write stalls the fill counter for that cycle, so no address is skipped.
module sprite_fill_engine
  import mouse_ctrl_pkg::*;
#(
  parameter int CD   = 12,
  parameter int ADDR = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            cpu_we,
  input  logic [ADDR-1:0] cpu_addr,
  input  logic [CD-1:0]   cpu_pixel,
  input  logic [CD-1:0]   fill_color,
  output logic            busy,
  output logic            ram_we,
  output logic [ADDR-1:0] ram_addr_w,
  output logic [CD-1:0]   ram_pixel
);

  localparam logic [ADDR:0] CNT_LAST = {1'b0, {ADDR{1'b1}}};
  localparam logic [ADDR:0] CNT_ONE  = {{ADDR{1'b0}}, 1'b1};

  fill_state_t     state, state_nxt;
  logic [ADDR:0]   cnt, cnt_nxt;
  logic            we_nxt;
  logic [ADDR-1:0] addr_nxt;
  logic [CD-1:0]   pixel_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ram_we     <= 1'b0;
      ram_addr_w <= '0;
      ram_pixel  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ram_we     <= we_nxt;
      ram_addr_w <= addr_nxt;
      ram_pixel  <= pixel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we_nxt    = 1'b0;
    addr_nxt  = ram_addr_w;
    pixel_nxt = ram_pixel;
    if (cpu_we) begin
      we_nxt    = 1'b1;
      addr_nxt  = cpu_addr;
      pixel_nxt = cpu_pixel;
    end
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
        end
      end
      FILL: begin
        // The fill only advances on cycles the CPU leaves the port free.
        if (!cpu_we) begin
          we_nxt    = 1'b1;
          addr_nxt  = cnt[ADDR-1:0];
          pixel_nxt = fill_color;
          cnt_nxt   = cnt + CNT_ONE;
          if (cnt == CNT_LAST) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == FILL);

endmodule

// File: rtl/mouse_sprite_ctrl.sv
// Register-mapped mouse sprite controller: bus decode, frame-synchronous origin/enable shadows, fill engine.
// Latency: RAM port one cycle after the bus write; origin/enable take effect on frame_start.
// Backpressure: none on the bus; commands while busy are dropped.
module mouse_sprite_ctrl
  import mouse_ctrl_pkg::*;
#(
  parameter int            CD        = 12,
  parameter int            ADDR      = 10,
  parameter logic [CD-1:0] KEY_COLOR = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cs,
  input  logic            write,
  input  logic [ADDR:0]   addr,
  input  logic [31:0]     wr_data,
  output logic [31:0]     rd_data,
  input  logic            frame_start,
  output logic            ram_we,
  output logic [ADDR-1:0] ram_addr_w,
  output logic [CD-1:0]   ram_pixel,
  output logic [10:0]     x0,
  output logic [10:0]     y0,
  output logic            sprite_en
);

  logic          bus_wr, reg_wr, ram_wr, start, busy;
  logic [1:0]    reg_sel;
  logic [10:0]   x0_pend, y0_pend;
  logic          en_pend;
  logic [CD-1:0] fill_color;
  logic          unused_bits;

  assign bus_wr  = cs && write;
  assign reg_wr  = bus_wr && addr[ADDR];
  assign ram_wr  = bus_wr && !addr[ADDR];
  assign reg_sel = addr[1:0];
  assign start   = reg_wr && (reg_sel == REG_CMD) && wr_data[0];

  assign unused_bits = ^{wr_data, addr};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_pend    <= '0;
      y0_pend    <= '0;
      en_pend    <= 1'b0;
      fill_color <= KEY_COLOR;
    end else if (reg_wr) begin
      case (reg_sel)
        REG_POS: begin
          x0_pend <= wr_data[10:0];
          y0_pend <= wr_data[26:16];
        end
        REG_CTRL: en_pend    <= wr_data[0];
        REG_FILL: fill_color <= wr_data[CD-1:0];
        default:  ;
      endcase
    end
  end

  // Applied copies sample the pending value before any same-cycle bus write lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0        <= '0;
      y0        <= '0;
      sprite_en <= 1'b0;
    end else if (frame_start) begin
      x0        <= x0_pend;
      y0        <= y0_pend;
      sprite_en <= en_pend;
    end
  end

  sprite_fill_engine #(
    .CD   (CD),
    .ADDR (ADDR)
  ) u_fill (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .cpu_we     (ram_wr),
    .cpu_addr   (addr[ADDR-1:0]),
    .cpu_pixel  (wr_data[CD-1:0]),
    .fill_color (fill_color),
    .busy       (busy),
    .ram_we     (ram_we),
    .ram_addr_w (ram_addr_w),
    .ram_pixel  (ram_pixel)
  );

  always_comb begin
    rd_data = '0;
    if (addr[0] == RD_POS) rd_data = {5'b0, y0, 5'b0, x0};
    else                   rd_data = {29'b0, busy, sprite_en, 1'b0};
  end

endmodule

// File: doc/mouse_sprite_ctrl.md
Name: mouse_sprite_ctrl

Overview:
Register-mapped controller for the mouse sprite pixel-generation datapath. It owns the datapath's sprite RAM write port (we/addr_w/pixel_in) and its origin inputs (x0/y0).
- Shares the RAM write port between direct CPU pixel writes and an internal hardware fill engine.
- Double-buffers the sprite origin and enable so they change only at frame start, which prevents a torn cursor.
- Sits between the MMIO bus slot and the sprite pixel source, alongside the frame counter.

Parameters:
CD, 12, colour depth of a sprite pixel.
ADDR, 10, sprite RAM address width (32x32 sprite = 1024 entries).
KEY_COLOR, 0, chroma-key value loaded into the fill-colour register on reset.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
cs  in  1  bus slot select.
write  in  1  bus write strobe; a write is accepted when cs && write.
addr  in  ADDR+1  bus address; addr[ADDR]=0 selects RAM, addr[ADDR]=1 selects registers via addr[1:0].
wr_data  in  32  bus write data.
rd_data  out  32  {29'b0, busy, en_act, 1'b0} when addr[0]=0; {5'b0, y0_act, 5'b0, x0_act} when addr[0]=1.
frame_start  in  1  one-cycle pulse from the frame counter at pixel (0,0).
ram_we  out  1  sprite RAM write enable.
ram_addr_w  out  ADDR  sprite RAM write address.
ram_pixel  out  CD  sprite RAM write data.
x0  out  11  applied sprite origin x.
y0  out  11  applied sprite origin y.
sprite_en  out  1  applied sprite enable; downstream uses it to select sprite or bypass.

Behaviour:
Register map (addr[ADDR]=1):
- reg0 (write): position; x0_pend <= wr_data[10:0], y0_pend <= wr_data[26:16].
- reg1 (write): control; en_pend <= wr_data[0].
- reg2 (write): fill colour; fill_color <= wr_data[CD-1:0].
- reg3 (write): command; wr_data[0]=1 starts a fill. Ignored while busy.

Reset values:
- x0_pend, y0_pend, x0, y0, fill counter: 0.
- en_pend, sprite_en: 0.
- fill_color: KEY_COLOR.
- ram_we: 0; ram_addr_w: 0; ram_pixel: 0.
- FSM: IDLE.

Outputs: ram_we, ram_addr_w, ram_pixel, x0, y0 and sprite_en are all registered outputs.

Shadow update:
- On frame_start: x0 <= x0_pend, y0 <= y0_pend, sprite_en <= en_pend.
- If a bus write to reg0 or reg1 coincides with frame_start, the applied registers take the OLD pending value. The new value is applied at the next frame_start.

Direct RAM write:
- cs && write && !addr[ADDR] gives ram_we=1, ram_addr_w=addr[ADDR-1:0], ram_pixel=wr_data[CD-1:0].
- These appear the cycle after the bus write (1-cycle latency).

Fill FSM states: IDLE, FILL.
- IDLE -> FILL on a command write with bit0=1. Counter cnt <= 0.
- In FILL, each cycle without a CPU RAM write issues ram_we=1, ram_addr_w=cnt, ram_pixel=fill_color, then cnt++.
- CPU RAM write in the same cycle: the CPU wins the port and cnt holds, so no fill address is skipped.
- FILL -> IDLE after the write to address 2^ADDR-1. Fill takes exactly 2^ADDR cycles with no CPU contention.
- busy=1 throughout FILL.
- A fill-colour write during FILL takes effect on the next fill word.
- A command write during FILL is ignored; the fill does not restart.

Reads: rd_data is combinational from the applied registers and status. RAM contents are not readable.

Reset mid-fill: returns to IDLE, ram_we=0 immediately (asynchronous). RAM contents are left partial.

Arithmetic: cnt is ADDR+1 bits wide, and terminal detection is cnt==2^ADDR-1. No wrap beyond the last address.

Decomposition:
Package mouse_ctrl_pkg holds:
- typedef enum logic {IDLE, FILL} fill_state_t.
- Register offset constants REG_POS=0, REG_CTRL=1, REG_FILL=2, REG_CMD=3.
- RD_STATUS=0, RD_POS=1.

Sub-module: one is natural. sprite_fill_engine contains the FSM, counter and port-grant mux. Shadow registers and the bus decoder stay in the top level.

Test Plan:
1. Reset then read reg0: rd_data=0. x0=y0=0, sprite_en=0, ram_we=0.
2. Write reg0=0x0064_00C8 and reg1=1, no frame_start: x0=0, sprite_en=0. Pulse frame_start: next cycle x0=200, y0=100, sprite_en=1.
3. Write reg0 and pulse frame_start in the same cycle: applied values stay the old values. The next frame_start applies 200/100.
4. Write reg2=0xF00, then reg3=1: busy=1 for 1024 cycles. ram_addr_w runs 0..1023 with ram_pixel=0xF00 each cycle, then busy=0.
5. During a fill at cnt=5, issue a CPU RAM write to addr 0x3FF with 0x0AB:
   - That cycle: ram_addr_w=0x3FF, ram_pixel=0x0AB.
   - Next cycle: fill resumes at 5.
   - Total fill time is 1025 cycles.
6. Assert reset_n=0 at cnt=300: ram_we drops immediately. After release, busy=0, and a new reg3 write restarts the fill from address 0.
